// File: rtl/strand_restart_sequencer.sv
// Per-strand restart sequencer: receives rollbacks from the rollback controller,
// drains the pipeline, parks suspended/retrying strands until resumed, then
// requests a restart from fetch and gates the strand-ready mask.
module strand_restart_sequencer #(
  parameter int unsigned STRANDS      = 4,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [STRANDS-1:0]           rb_rollback_strand,
  input  logic [STRANDS*32-1:0]        rb_rollback_pc,
  input  logic [STRANDS*4-1:0]         rb_rollback_reg_lane,
  input  logic [STRANDS-1:0]           rb_suspend_strand,
  input  logic [STRANDS-1:0]           rb_retry_strand,
  input  logic [STRANDS-1:0]           resume_strand,
  input  logic [STRANDS-1:0]           strand_enable,
  input  logic [STRANDS-1:0]           if_restart_ack,
  output logic [STRANDS-1:0]           if_restart_strand,
  output logic [STRANDS*32-1:0]        if_restart_pc,
  output logic [STRANDS*4-1:0]         ss_reg_lane,
  output logic [STRANDS-1:0]           ss_strand_ready,
  output logic [$clog2(STRANDS+1)-1:0] suspended_count
);

  localparam int unsigned CntW   = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned CountW = $clog2(STRANDS + 1);
  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StDrain, StSuspend, StRestart} state_e;

  state_e                state_q [STRANDS];
  state_e                state_d [STRANDS];
  logic [CntW-1:0]       cnt_q   [STRANDS];
  logic [CntW-1:0]       cnt_d   [STRANDS];
  logic [STRANDS*32-1:0] pc_q, pc_d;
  logic [STRANDS*4-1:0]  lane_q, lane_d;
  logic [STRANDS-1:0]    restart_q, restart_d;
  logic [CountW-1:0]     count_q, count_d;

  // Next-state logic for every strand; a rollback overrides whatever the strand is doing.
  always_comb begin
    pc_d      = pc_q;
    lane_d    = lane_q;
    restart_d = '0;
    count_d   = '0;
    for (int i = 0; i < int'(STRANDS); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (rb_rollback_strand[i]) begin
        pc_d[i*32 +: 32] = rb_rollback_pc[i*32 +: 32];
        lane_d[i*4 +: 4] = rb_rollback_reg_lane[i*4 +: 4];
        // A resume arriving with the suspending rollback skips the park entirely.
        if ((rb_suspend_strand[i] || rb_retry_strand[i]) && !resume_strand[i]) begin
          state_d[i] = StSuspend;
        end else begin
          state_d[i] = StDrain;
          cnt_d[i]   = DrainLoad;
        end
      end else begin
        unique case (state_q[i])
          StRun: ;
          StDrain: begin
            if (cnt_q[i] == '0) state_d[i] = StRestart;
            else                cnt_d[i]   = cnt_q[i] - CntW'(1);
          end
          StSuspend: begin
            if (resume_strand[i]) begin
              state_d[i] = StDrain;
              cnt_d[i]   = DrainLoad;
            end
          end
          StRestart: begin
            if (if_restart_ack[i]) state_d[i] = StRun;
          end
          default: state_d[i] = StRun;
        endcase
      end
      restart_d[i] = (state_d[i] == StRestart);
      if (state_d[i] == StSuspend) count_d = count_d + CountW'(1);
    end
  end

  // State, latched restart context and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(STRANDS); i++) begin
        state_q[i] <= StRun;
        cnt_q[i]   <= '0;
      end
      pc_q      <= '0;
      lane_q    <= '0;
      restart_q <= '0;
      count_q   <= '0;
    end else begin
      for (int i = 0; i < int'(STRANDS); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pc_q      <= pc_d;
      lane_q    <= lane_d;
      restart_q <= restart_d;
      count_q   <= count_d;
    end
  end

  // Only running strands may issue; enable merely gates the mask.
  always_comb begin
    ss_strand_ready = '0;
    for (int i = 0; i < int'(STRANDS); i++) begin
      ss_strand_ready[i] = (state_q[i] == StRun) && strand_enable[i];
    end
  end

  assign if_restart_strand = restart_q;
  assign if_restart_pc     = pc_q;
  assign ss_reg_lane       = lane_q;
  assign suspended_count   = count_q;

endmodule

// File: tb/tb_strand_restart_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a timestamp-based reference model of each strand.
module tb_strand_restart_sequencer;

  localparam int S = 4;
  localparam int D = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [S-1:0]    rb_rollback_strand, rb_suspend_strand, rb_retry_strand;
  logic [S*32-1:0] rb_rollback_pc;
  logic [S*4-1:0]  rb_rollback_reg_lane;
  logic [S-1:0]    resume_strand, strand_enable, if_restart_ack;
  logic [S-1:0]    if_restart_strand, ss_strand_ready;
  logic [S*32-1:0] if_restart_pc;
  logic [S*4-1:0]  ss_reg_lane;
  logic [$clog2(S+1)-1:0] suspended_count;

  always #5 clk = ~clk;

  strand_restart_sequencer #(.STRANDS(S), .DRAIN_CYCLES(D)) dut (
    .clk                  (clk),
    .reset                (reset),
    .rb_rollback_strand   (rb_rollback_strand),
    .rb_rollback_pc       (rb_rollback_pc),
    .rb_rollback_reg_lane (rb_rollback_reg_lane),
    .rb_suspend_strand    (rb_suspend_strand),
    .rb_retry_strand      (rb_retry_strand),
    .resume_strand        (resume_strand),
    .strand_enable        (strand_enable),
    .if_restart_ack       (if_restart_ack),
    .if_restart_strand    (if_restart_strand),
    .if_restart_pc        (if_restart_pc),
    .ss_reg_lane          (ss_reg_lane),
    .ss_strand_ready      (ss_strand_ready),
    .suspended_count      (suspended_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: a strand is busy from rollback until an accepted ack; a parked strand waits
  // for resume; otherwise it requests restart from the absolute cycle restart_at onward.
  bit          m_busy  [S];
  bit          m_park  [S];
  int          m_rs_at [S];
  logic [31:0] m_pc    [S];
  logic [3:0]  m_lane  [S];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic model_edge();
    for (int i = 0; i < S; i++) begin
      if (reset) begin
        m_busy[i] = 0; m_park[i] = 0; m_rs_at[i] = 0; m_pc[i] = '0; m_lane[i] = '0;
      end else if (rb_rollback_strand[i]) begin
        m_pc[i]   = rb_rollback_pc[i*32 +: 32];
        m_lane[i] = rb_rollback_reg_lane[i*4 +: 4];
        m_busy[i] = 1;
        m_park[i] = (rb_suspend_strand[i] | rb_retry_strand[i]) & ~resume_strand[i];
        m_rs_at[i] = cyc + 1 + D;
      end else if (m_park[i]) begin
        if (resume_strand[i]) begin
          m_park[i]  = 0;
          m_rs_at[i] = cyc + 1 + D;
        end
      end else if (m_busy[i] && cyc >= m_rs_at[i] && if_restart_ack[i]) begin
        m_busy[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [S-1:0]    e_rs, e_rdy;
    logic [S*32-1:0] e_pc;
    logic [S*4-1:0]  e_lane;
    int              e_cnt;
    e_cnt = 0;
    for (int i = 0; i < S; i++) begin
      e_rs[i]  = m_busy[i] && !m_park[i] && cyc >= m_rs_at[i];
      e_rdy[i] = !m_busy[i] && strand_enable[i];
      e_pc[i*32 +: 32] = m_pc[i];
      e_lane[i*4 +: 4] = m_lane[i];
      e_cnt += int'(m_park[i]);
    end
    check_eq("restart", 128'(if_restart_strand), 128'(e_rs));
    check_eq("ready", 128'(ss_strand_ready), 128'(e_rdy));
    check_eq("pc", 128'(if_restart_pc), 128'(e_pc));
    check_eq("lane", 128'(ss_reg_lane), 128'(e_lane));
    check_eq("susp_cnt", 128'(suspended_count), 128'(e_cnt));
  endtask

  task automatic clear_pulses();
    rb_rollback_strand = '0; rb_suspend_strand = '0; rb_retry_strand = '0;
    resume_strand = '0; if_restart_ack = '0;
    rb_rollback_pc = '0; rb_rollback_reg_lane = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
    clear_pulses();
  endtask

  task automatic rollback(input int i, input logic [31:0] pc, input logic [3:0] lane,
                          input bit susp, input bit retry);
    rb_rollback_strand[i] = 1'b1;
    rb_rollback_pc[i*32 +: 32] = pc;
    rb_rollback_reg_lane[i*4 +: 4] = lane;
    rb_suspend_strand[i] = susp;
    rb_retry_strand[i] = retry;
  endtask

  initial begin
    clear_pulses();
    strand_enable = '1;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    // Plain rollback on strand 1.
    rollback(1, 32'h100, 4'h0, 0, 0);
    step();
    check_eq("t1_not_ready", 128'(ss_strand_ready[1]), 128'(0));
    repeat (D) step();
    check_eq("t1_restart", 128'(if_restart_strand[1]), 128'(1));
    check_eq("t1_pc", 128'(if_restart_pc[63:32]), 128'(32'h100));
    step();
    if_restart_ack[1] = 1'b1;
    step();
    check_eq("t1_ready", 128'(ss_strand_ready[1]), 128'(1));

    // Suspend on strand 2, parked for 50 cycles, then resumed.
    rollback(2, 32'h2000, 4'h5, 1, 0);
    step();
    for (int k = 0; k < 50; k++) begin
      check_eq("t2_parked", 128'(suspended_count), 128'(1));
      step();
    end
    resume_strand[2] = 1'b1;
    step();
    check_eq("t2_cnt0", 128'(suspended_count), 128'(0));
    repeat (D) step();
    check_eq("t2_restart", 128'(if_restart_strand[2]), 128'(1));
    check_eq("t2_pc", 128'(if_restart_pc[95:64]), 128'(32'h2000));
    check_eq("t2_lane", 128'(ss_reg_lane[11:8]), 128'(5));
    if_restart_ack[2] = 1'b1;
    step();

    // Second rollback while draining on strand 0.
    rollback(0, 32'h40, 4'h1, 0, 0);
    step(); step();
    rollback(0, 32'h80, 4'h2, 0, 0);
    step();
    repeat (D) step();
    check_eq("t3_restart", 128'(if_restart_strand[0]), 128'(1));
    check_eq("t3_pc", 128'(if_restart_pc[31:0]), 128'(32'h80));
    if_restart_ack[0] = 1'b1;
    step();

    // Ack and new rollback collide on strand 3.
    rollback(3, 32'h30, 4'h3, 0, 0);
    step();
    repeat (D) step();
    check_eq("t4_restart1", 128'(if_restart_strand[3]), 128'(1));
    if_restart_ack[3] = 1'b1;
    rollback(3, 32'h300, 4'h4, 0, 0);
    step();
    for (int k = 0; k < D; k++) begin
      check_eq("t4_no_ready", 128'(ss_strand_ready[3]), 128'(0));
      step();
    end
    check_eq("t4_restart2", 128'(if_restart_strand[3]), 128'(1));
    check_eq("t4_pc", 128'(if_restart_pc[127:96]), 128'(32'h300));
    if_restart_ack[3] = 1'b1;
    step();

    // Retry rollback together with resume on strand 1.
    rollback(1, 32'h111, 4'h6, 0, 1);
    resume_strand[1] = 1'b1;
    step();
    check_eq("t5_cnt", 128'(suspended_count), 128'(0));
    repeat (D) step();
    check_eq("t5_restart", 128'(if_restart_strand[1]), 128'(1));
    if_restart_ack[1] = 1'b1;
    step();

    // All strands suspended, then a one-cycle reset.
    for (int i = 0; i < S; i++) rollback(i, 32'h1000 + 32'(i), 4'(i + 8), 1, 0);
    step();
    check_eq("t6_cnt4", 128'(suspended_count), 128'(4));
    strand_enable = 4'b1011;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t6_cnt0", 128'(suspended_count), 128'(0));
    check_eq("t6_pc", 128'(if_restart_pc), 128'(0));
    check_eq("t6_ready", 128'(ss_strand_ready), 128'(4'b1011));
    step();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < S; i++) begin
        strand_enable[i] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 9) == 0) begin
          rollback(i, $urandom(), 4'($urandom()),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end
        resume_strand[i]  = ($urandom_range(0, 5) == 0);
        if_restart_ack[i] = ($urandom_range(0, 1) == 0);
      end
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
